io_deserializer: RTL and testbench
==================================

# io_deserializer

Serial-to-parallel receiver for uDMA peripheral channels. It is the receive-side counterpart of the channel's serializing shift register. It samples `serial_i` on a bit strobe and assembles words of 1 to DATA_WIDTH bits, MSB-first or LSB-first. Each completed word is handed to the uDMA RX datapath through a one-entry valid/ready output buffer, and an overrun is reported as a sticky flag.

## Interface
- `DATA_WIDTH`, 32: maximum word width in bits; must be at least 2.
- `LEN_WIDTH`, `$clog2(DATA_WIDTH)`: width of the word-length field.

- `clk_i`  in  1  clock; everything is rising-edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `en_i`  in  1  receive enable; sample strobes are ignored while it is low.
- `clear_i`  in  1  synchronous abort: flushes the partial word and the output buffer, and clears `overflow_o`.
- `lsbfirst_i`  in  1  bit order of the incoming word.
- `len_i`  in  LEN_WIDTH  word length minus 1 (0 means 1 bit, DATA_WIDTH-1 means full width).
- `serial_i`  in  1  serial data.
- `sample_i`  in  1  single-cycle bit strobe; `serial_i` is captured in a cycle where `sample_i` and `en_i` are both high.
- `data_o`  out  DATA_WIDTH  received word, right-aligned, unused upper bits zero.
- `valid_o`  out  1  `data_o` holds an unconsumed word.
- `ready_i`  in  1  consumer accepts `data_o`; a transfer occurs when `valid_o` and `ready_i` are both high.
- `busy_o`  out  1  a word is partially received.
- `overflow_o`  out  1  sticky: a completed word was dropped.

## Operation
- State machine:
  - IDLE: bit counter is 0; nothing collected.
  - SHIFT: collecting bits.
  - IDLE -> SHIFT on the first accepted strobe. On this transition `len_i` and `lsbfirst_i` are latched for the whole word, and the assembly register is zeroed before the bit is inserted.
  - SHIFT -> IDLE when the last bit is accepted (counter equals latched len) or when `en_i` falls.
  - A word with `len_i`=0 completes on its first strobe and stays in IDLE.
- Bit insertion:
  - MSB-first: assembly register becomes `{asm[DATA_WIDTH-2:0], serial_i}`.
  - LSB-first: `serial_i` is written at index `bit_cnt`.
  - In both cases the result is right-aligned in bits [len:0].
- Word completion:
  - If the buffer is empty, or it is being consumed in the same cycle (`valid_o & ready_i`), the word is written to the buffer and `valid_o` is high next cycle.
  - Otherwise the new word is dropped, the buffer keeps the old word, and `overflow_o` is set.
- `en_i` low mid-word: the partial word is discarded and the FSM returns to IDLE. The buffer and `overflow_o` are untouched, and consumer handshakes still complete.
- `clear_i` has priority over everything except reset. Any strobe in the same cycle is ignored.
- Changing `len_i` or `lsbfirst_i` mid-word has no effect until the next word.

## Timing
- Reset values: `data_o`=0, `valid_o`=0, `busy_o`=0, `overflow_o`=0. The FSM is in IDLE with the counter at 0.
- Latency: the strobe accepting the last bit is in cycle N; `valid_o` and `data_o` update at the rising edge ending N and are visible in N+1.
- `busy_o` is registered and equals (state == SHIFT). It rises the cycle after the first accepted bit and falls the cycle after the last.
- `valid_o` deasserts the cycle after a transfer, unless a word completes in the transfer cycle.
- `data_o` is stable while `valid_o` is high and not yet accepted.
- Back-to-back strobes, one per cycle, are supported indefinitely. Throughput is one bit per cycle.
- `overflow_o` sets the cycle after the dropped completion and holds until `clear_i` or reset.
- A reset assertion mid-word clears all state immediately and asynchronously.

## Structure
- Package `io_deser_pkg`:
  - `deser_state_e` enum `{IDLE, SHIFT}`.
  - `LEN_WIDTH` derivation helper.
- Sub-module `io_deser_obuf`: one-entry valid/ready holding register with write, accept and overflow logic. It takes the inputs `wr_i`, `wdata_i`, `ready_i` and `clear_i`.
- The top level holds the FSM, the bit counter and the assembly register.

## Test plan
- MSB-first, `len_i`=7, bits 1,0,1,1,0,0,1,0 on consecutive strobes, `ready_i`=1 -> `data_o`=0x000000B2 with `valid_o` high for 1 cycle, one cycle after the 8th strobe.
- LSB-first, `len_i`=31, word 0xDEADBEEF sent LSB first -> `data_o`=0xDEADBEEF; `busy_o` high from cycle 2 through cycle 32.
- `ready_i`=0, two 4-bit words 0xA then 0x5 -> `data_o` holds 0xA and `overflow_o`=1. Then `ready_i`=1 -> one transfer of 0xA, `valid_o` drops, `overflow_o` stays 1 until `clear_i`.
- Buffer full with 0x3, a completing strobe coincides with `ready_i`=1 (next word 0xC, `len_i`=3) -> 0x3 is accepted, `valid_o` stays high with 0xC, `overflow_o`=0.
- `en_i` dropped after 5 of 8 bits, then a full 8-bit word 0xFF -> only 0x000000FF is delivered, with no stale bits.
- `rst_i` pulsed mid-word with `valid_o`=1 -> all outputs 0 immediately. `len_i`=0 with `serial_i`=1 afterwards -> `data_o`=0x1 after a single strobe.

Source files
------------

// File: rtl/io_deser_pkg.sv
// Shared types and helpers for the uDMA serial-to-parallel receiver.
package io_deser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_e;

  // Width of the "length minus one" field for a given maximum word width.
  function automatic int deser_len_width(input int data_width);
    return (data_width < 2) ? 1 : $clog2(data_width);
  endfunction

endpackage

// File: rtl/io_deser_obuf.sv
// One-entry valid/ready output buffer with a sticky overflow flag for dropped words.
module io_deser_obuf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  overflow_o
);

  logic can_write;

  // A slot is free when empty or when the held word leaves in this same cycle.
  assign can_write = ~valid_o | ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      data_o     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else if (wr_i && can_write) begin
      data_o  <= wdata_i;
      valid_o <= 1'b1;
    end else if (wr_i) begin
      overflow_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/io_deserializer.sv
// uDMA RX deserializer: collects strobed serial bits into 1..DATA_WIDTH-bit words,
// MSB- or LSB-first, and hands them to a one-entry valid/ready buffer.
module io_deserializer
  import io_deser_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = deser_len_width(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic                  lsbfirst_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  serial_i,
  input  logic                  sample_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  overflow_o
);

  deser_state_e          state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  lsb_q, lsb_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;

  logic [LEN_WIDTH-1:0]  cur_len;
  logic                  cur_lsb;
  logic [DATA_WIDTH-1:0] asm_base, asm_ins;
  logic                  accept, last, wr;

  assign accept = en_i & sample_i & ~clear_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    lsb_d   = lsb_q;
    asm_d   = asm_q;

    // The first bit of a word uses the live configuration and a zeroed register.
    cur_len  = (state_q == IDLE) ? len_i      : len_q;
    cur_lsb  = (state_q == IDLE) ? lsbfirst_i : lsb_q;
    asm_base = (state_q == IDLE) ? '0         : asm_q;

    asm_ins = asm_base;
    if (cur_lsb) asm_ins[cnt_q] = serial_i;
    else         asm_ins = {asm_base[DATA_WIDTH-2:0], serial_i};

    last = (cnt_q == cur_len);
    wr   = accept & last;

    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == SHIFT && !en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = SHIFT;
        cnt_d   = cnt_q + LEN_WIDTH'(1);
        asm_d   = asm_ins;
        len_d   = cur_len;
        lsb_d   = cur_lsb;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      lsb_q   <= 1'b0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      lsb_q   <= lsb_d;
      asm_q   <= asm_d;
    end
  end

  assign busy_o = (state_q == SHIFT);

  io_deser_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .wr_i       (wr),
    .wdata_i    (asm_ins),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .overflow_o (overflow_o)
  );

endmodule

// File: tb/tb_io_deserializer.sv
// Directed self-checking bench for io_deserializer.
module tb_io_deserializer;

  localparam int DW = 32;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          clear = 1'b0;
  logic          lsbfirst = 1'b0;
  logic [LW-1:0] len = '0;
  logic          serial = 1'b0;
  logic          sample = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] data;
  logic          valid;
  logic          busy;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;

  io_deserializer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .clear_i    (clear),
    .lsbfirst_i (lsbfirst),
    .len_i      (len),
    .serial_i   (serial),
    .sample_i   (sample),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .busy_o     (busy),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial = b;
    sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  task automatic idle_cycle();
    sample = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] w;

    // Reset state
    tick(); tick();
    check("rst_data", data, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_ovf", {31'b0, overflow}, 32'h0);
    rst = 1'b0;
    tick();

    // MSB-first 8-bit word 0xB2
    en = 1'b1; lsbfirst = 1'b0; len = 5'd7; ready = 1'b1;
    w = 32'hB2;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      if (i == 7) check("msb_busy_rise", {31'b0, busy}, 32'h1);
      if (i == 1) check("msb_no_early_valid", {31'b0, valid}, 32'h0);
    end
    check("msb_data", data, 32'h0000_00B2);
    check("msb_valid", {31'b0, valid}, 32'h1);
    check("msb_busy_fall", {31'b0, busy}, 32'h0);
    idle_cycle();
    check("msb_valid_drop", {31'b0, valid}, 32'h0);

    // LSB-first full-width word
    lsbfirst = 1'b1; len = 5'd31;
    w = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) begin
      send_bit(w[i]);
      if (i == 30) check("lsb_busy_31", {31'b0, busy}, 32'h1);
    end
    check("lsb_data", data, 32'hDEADBEEF);
    check("lsb_valid", {31'b0, valid}, 32'h1);
    check("lsb_busy_fall", {31'b0, busy}, 32'h0);
    idle_cycle();

    // Overflow: 0xA held, 0x5 dropped
    lsbfirst = 1'b0; len = 5'd3; ready = 1'b0;
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    check("ovf_first_data", data, 32'hA);
    check("ovf_first_valid", {31'b0, valid}, 32'h1);
    send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    check("ovf_held_data", data, 32'hA);
    check("ovf_set", {31'b0, overflow}, 32'h1);
    ready = 1'b1;
    idle_cycle();
    check("ovf_drain_valid", {31'b0, valid}, 32'h0);
    check("ovf_sticky", {31'b0, overflow}, 32'h1);
    ready = 1'b0;
    idle_cycle();
    check("ovf_still_sticky", {31'b0, overflow}, 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("ovf_cleared", {31'b0, overflow}, 32'h0);

    // Completion coinciding with a consumer transfer
    send_bit(0); send_bit(0); send_bit(1); send_bit(1);
    check("cc_first_data", data, 32'h3);
    send_bit(1); send_bit(1); send_bit(0);
    check("cc_hold_data", data, 32'h3);
    ready = 1'b1;
    send_bit(0);
    check("cc_valid", {31'b0, valid}, 32'h1);
    check("cc_data", data, 32'hC);
    check("cc_no_ovf", {31'b0, overflow}, 32'h0);
    idle_cycle();
    check("cc_drain", {31'b0, valid}, 32'h0);

    // Enable dropped mid-word, then a clean 0xFF
    len = 5'd7;
    send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    check("en_busy", {31'b0, busy}, 32'h1);
    en = 1'b0;
    idle_cycle();
    check("en_abort_busy", {31'b0, busy}, 32'h0);
    check("en_abort_valid", {31'b0, valid}, 32'h0);
    en = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(1);
    check("en_full_data", data, 32'h0000_00FF);
    check("en_full_valid", {31'b0, valid}, 32'h1);
    idle_cycle();

    // Clear has priority over a coincident strobe
    len = 5'd0;
    clear = 1'b1;
    send_bit(1);
    clear = 1'b0;
    check("clr_prio_valid", {31'b0, valid}, 32'h0);

    // Asynchronous reset mid-word with a held word
    ready = 1'b0; len = 5'd3;
    send_bit(1); send_bit(0); send_bit(0); send_bit(1);
    check("ar_pre_valid", {31'b0, valid}, 32'h1);
    send_bit(1); send_bit(1);
    check("ar_pre_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("ar_data", data, 32'h0);
    check("ar_valid", {31'b0, valid}, 32'h0);
    check("ar_busy", {31'b0, busy}, 32'h0);
    check("ar_ovf", {31'b0, overflow}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Single-bit word after reset
    len = 5'd0;
    send_bit(1);
    check("len0_data", data, 32'h1);
    check("len0_valid", {31'b0, valid}, 32'h1);
    check("len0_busy", {31'b0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
